lsu_mem_ctrl: RTL and testbench

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_load_extend.sv | 24 ++
 rtl/lsu_mem_ctrl.sv | 123 ++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit memory controller.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_DONE  = 2'b11
   } lsu_state_e;

   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_BYTE = 2'b01;
   localparam logic [1:0] SIZE_HALF = 2'b10;

   localparam int LSU_TIMEOUT_DEFAULT = 16;

   function automatic logic size_legal(input logic [1:0] size);
      return (size != 2'b11);
   endfunction

   // Low address bits presented to memory encode the access width, not the byte lane.
   function automatic logic [1:0] addr_code(input logic [1:0] size);
      logic [1:0] code;
      case (size)
         SIZE_BYTE: code = 2'b01;
         SIZE_HALF: code = 2'b10;
         SIZE_WORD: code = 2'b00;
         default:   code = 2'b00;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational size/sign extender for load data returned by memory.
module lsu_load_extend
   import lsu_pkg::*;
#(
   parameter int WORD_SIZE = 32
) (
   input  logic [1:0]           size,
   input  logic                 sign_ext,
   input  logic [WORD_SIZE-1:0] rdata,
   output logic [WORD_SIZE-1:0] result
);

   // Select the low lane for the access width and fill the upper bits.
   always_comb begin
      result = rdata;
      case (size)
         SIZE_BYTE: result = {{(WORD_SIZE-8){sign_ext & rdata[7]}}, rdata[7:0]};
         SIZE_HALF: result = {{(WORD_SIZE-16){sign_ext & rdata[15]}}, rdata[15:0]};
         SIZE_WORD: result = rdata;
         default:   result = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit controller: turns MEM-stage requests into single memory
// bus transactions with timeout, stall and extended load results.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int WORD_SIZE    = 32,
   parameter int ADDRESS_SIZE = 32,
   parameter int TIMEOUT      = LSU_TIMEOUT_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cpu_req,
   input  logic                    cpu_rnw,
   input  logic [1:0]              cpu_size,
   input  logic                    cpu_signed,
   input  logic [ADDRESS_SIZE-1:0] cpu_addr,
   input  logic [WORD_SIZE-1:0]    cpu_wdata,
   output logic [WORD_SIZE-1:0]    cpu_rdata,
   output logic                    cpu_done,
   output logic                    cpu_stall,
   output logic                    cpu_err,
   output logic                    mem_enable,
   output logic                    mem_readnotwrite,
   output logic [ADDRESS_SIZE-1:0] mem_address,
   output logic [WORD_SIZE-1:0]    mem_wdata,
   output logic                    mem_wdata_oe,
   input  logic [WORD_SIZE-1:0]    mem_rdata,
   input  logic                    mem_data_ready
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   lsu_state_e          state_r;
   logic [CNT_W-1:0]    wait_cnt_r;
   logic [1:0]          size_r;
   logic                signed_r;
   logic [WORD_SIZE-1:0] ext_s;
   logic                unused_addr_s;

   assign unused_addr_s = ^cpu_addr[1:0];

   lsu_load_extend #(
      .WORD_SIZE(WORD_SIZE)
   ) u_load_extend (
      .size     (size_r),
      .sign_ext (signed_r),
      .rdata    (mem_rdata),
      .result   (ext_s)
   );

   assign cpu_stall = (state_r != ST_IDLE) | ((state_r == ST_IDLE) & cpu_req);

   // Access sequencer; all bus and CPU-side outputs are registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r          <= ST_IDLE;
         wait_cnt_r       <= {CNT_W{1'b0}};
         size_r           <= SIZE_WORD;
         signed_r         <= 1'b0;
         cpu_rdata        <= {WORD_SIZE{1'b0}};
         cpu_done         <= 1'b0;
         cpu_err          <= 1'b0;
         mem_enable       <= 1'b0;
         mem_readnotwrite <= 1'b1;
         mem_address      <= {ADDRESS_SIZE{1'b0}};
         mem_wdata        <= {WORD_SIZE{1'b0}};
         mem_wdata_oe     <= 1'b0;
      end else begin
         cpu_done <= 1'b0;
         cpu_err  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (cpu_req) begin
                  if (size_legal(cpu_size)) begin
                     size_r           <= cpu_size;
                     signed_r         <= cpu_signed;
                     mem_readnotwrite <= cpu_rnw;
                     mem_address      <= {cpu_addr[ADDRESS_SIZE-1:2], addr_code(cpu_size)};
                     mem_wdata        <= cpu_wdata;
                     mem_enable       <= 1'b1;
                     mem_wdata_oe     <= ~cpu_rnw;
                     wait_cnt_r       <= {CNT_W{1'b0}};
                     state_r          <= ST_ISSUE;
                  end else begin
                     cpu_err <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               wait_cnt_r <= {CNT_W{1'b0}};
               state_r    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (mem_data_ready) begin
                  if (mem_readnotwrite) begin
                     cpu_rdata <= ext_s;
                  end
                  mem_enable   <= 1'b0;
                  mem_wdata_oe <= 1'b0;
                  cpu_done     <= 1'b1;
                  state_r      <= ST_DONE;
               end else if (wait_cnt_r == CNT_W'(TIMEOUT - 1)) begin
                  mem_enable   <= 1'b0;
                  mem_wdata_oe <= 1'b0;
                  cpu_err      <= 1'b1;
                  state_r      <= ST_IDLE;
               end else begin
                  wait_cnt_r <= wait_cnt_r + CNT_W'(1);
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               mem_enable   <= 1'b0;
               mem_wdata_oe <= 1'b0;
               state_r      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed, scoreboard-based bench for lsu_mem_ctrl.
module tb_lsu_mem_ctrl;

   logic        clk;
   logic        rst;
   logic        cpu_req;
   logic        cpu_rnw;
   logic [1:0]  cpu_size;
   logic        cpu_signed;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_done;
   logic        cpu_stall;
   logic        cpu_err;
   logic        mem_enable;
   logic        mem_readnotwrite;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic        mem_wdata_oe;
   logic [31:0] mem_rdata;
   logic        mem_data_ready;

   typedef struct {
      bit          is_err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb_q[$];
   int   pass_cnt = 0;
   int   fail_cnt = 0;
   int   done_cnt = 0;

   lsu_mem_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .cpu_req          (cpu_req),
      .cpu_rnw          (cpu_rnw),
      .cpu_size         (cpu_size),
      .cpu_signed       (cpu_signed),
      .cpu_addr         (cpu_addr),
      .cpu_wdata        (cpu_wdata),
      .cpu_rdata        (cpu_rdata),
      .cpu_done         (cpu_done),
      .cpu_stall        (cpu_stall),
      .cpu_err          (cpu_err),
      .mem_enable       (mem_enable),
      .mem_readnotwrite (mem_readnotwrite),
      .mem_address      (mem_address),
      .mem_wdata        (mem_wdata),
      .mem_wdata_oe     (mem_wdata_oe),
      .mem_rdata        (mem_rdata),
      .mem_data_ready   (mem_data_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert (obs === exp) pass_cnt = pass_cnt + 1;
      else begin
         fail_cnt = fail_cnt + 1;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Completion/error monitor: pops the scoreboard on every DUT response.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst && (cpu_done || cpu_err)) begin
         if (cpu_done) done_cnt = done_cnt + 1;
         if (sb_q.size() == 0) begin
            check("sb_unexpected_response", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("sb_kind_err", {31'd0, cpu_err}, {31'd0, e.is_err});
            if (!e.is_err) check("sb_rdata", cpu_rdata, e.rdata);
         end
      end
   end

   task automatic do_access(input string tag, input logic rnw, input logic [1:0] size,
                            input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdat, input int k,
                            input logic [31:0] exp_rdata, input logic [31:0] exp_addr);
      @(negedge clk);
      cpu_req = 1'b1; cpu_rnw = rnw; cpu_size = size; cpu_signed = sgn;
      cpu_addr = addr; cpu_wdata = wdata;
      sb_q.push_back('{1'b0, exp_rdata});
      #1;
      check({tag, "_stall_req"}, {31'd0, cpu_stall}, 32'd1);
      @(posedge clk); #1;
      cpu_req = 1'b0;
      check({tag, "_addr"}, mem_address, exp_addr);
      check({tag, "_en_issue"}, {31'd0, mem_enable}, 32'd1);
      check({tag, "_oe_issue"}, {31'd0, mem_wdata_oe}, {31'd0, ~rnw});
      check({tag, "_rnw"}, {31'd0, mem_readnotwrite}, {31'd0, rnw});
      if (!rnw) check({tag, "_wdata"}, mem_wdata, wdata);
      repeat (k) @(posedge clk);
      #1;
      check({tag, "_en_wait"}, {31'd0, mem_enable}, 32'd1);
      check({tag, "_stall_wait"}, {31'd0, cpu_stall}, 32'd1);
      mem_rdata = rdat; mem_data_ready = 1'b1;
      @(posedge clk); #1;
      mem_data_ready = 1'b0;
      check({tag, "_done"}, {31'd0, cpu_done}, 32'd1);
      check({tag, "_en_done"}, {31'd0, mem_enable}, 32'd0);
      check({tag, "_oe_done"}, {31'd0, mem_wdata_oe}, 32'd0);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, {31'd0, cpu_done}, 32'd0);
      check({tag, "_stall_idle"}, {31'd0, cpu_stall}, 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rdata"}, cpu_rdata, 32'd0);
      check({tag, "_done"}, {31'd0, cpu_done}, 32'd0);
      check({tag, "_err"}, {31'd0, cpu_err}, 32'd0);
      check({tag, "_en"}, {31'd0, mem_enable}, 32'd0);
      check({tag, "_oe"}, {31'd0, mem_wdata_oe}, 32'd0);
      check({tag, "_addr"}, mem_address, 32'd0);
      check({tag, "_rnw"}, {31'd0, mem_readnotwrite}, 32'd1);
      check({tag, "_stall"}, {31'd0, cpu_stall}, 32'd0);
   endtask

   initial begin
      int n;
      int d0;
      rst = 1'b0; cpu_req = 1'b0; cpu_rnw = 1'b1; cpu_size = 2'b00; cpu_signed = 1'b0;
      cpu_addr = 32'd0; cpu_wdata = 32'd0; mem_rdata = 32'd0; mem_data_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      @(negedge clk); rst = 1'b1;

      do_access("word_ld", 1'b1, 2'b00, 1'b0, 32'h0000_0040, 32'd0, 32'hDEAD_BEEF, 2,
                32'hDEAD_BEEF, 32'h0000_0040);
      do_access("sbyte_ld", 1'b1, 2'b01, 1'b1, 32'h0000_0023, 32'd0, 32'h0000_00F3, 1,
                32'hFFFF_FFF3, 32'h0000_0021);
      do_access("ubyte_ld", 1'b1, 2'b01, 1'b0, 32'h0000_0023, 32'd0, 32'h0000_00F3, 1,
                32'h0000_00F3, 32'h0000_0021);
      do_access("shalf_ld", 1'b1, 2'b10, 1'b1, 32'h0000_0010, 32'd0, 32'h7777_8001, 3,
                32'hFFFF_8001, 32'h0000_0012);
      do_access("uhalf_ld", 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 32'h7777_8001, 1,
                32'h0000_8001, 32'h0000_0012);
      // Store leaves the last load result untouched.
      do_access("half_st", 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h1234_ABCD, 32'hFFFF_FFFF, 2,
                32'h0000_8001, 32'h0000_0102);

      // Illegal size: error pulse, no bus activity.
      @(negedge clk);
      cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_size = 2'b11; cpu_addr = 32'h0000_0050;
      sb_q.push_back('{1'b1, 32'd0});
      @(posedge clk); #1;
      cpu_req = 1'b0;
      check("illegal_err", {31'd0, cpu_err}, 32'd1);
      check("illegal_en", {31'd0, mem_enable}, 32'd0);
      @(posedge clk); #1;
      check("illegal_err_pulse", {31'd0, cpu_err}, 32'd0);
      check("illegal_stall", {31'd0, cpu_stall}, 32'd0);

      // Timeout: ready never comes; error 18 edges after the request edge.
      @(negedge clk);
      cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_size = 2'b00; cpu_addr = 32'h0000_0080;
      sb_q.push_back('{1'b1, 32'd0});
      @(posedge clk); #1;
      cpu_req = 1'b0;
      n = 1;
      while (!cpu_err && n < 40) begin
         @(posedge clk); #1;
         n = n + 1;
      end
      check("timeout_cycles", n, 32'd18);
      check("timeout_err", {31'd0, cpu_err}, 32'd1);
      check("timeout_en", {31'd0, mem_enable}, 32'd0);
      check("timeout_done", {31'd0, cpu_done}, 32'd0);
      check("timeout_stall", {31'd0, cpu_stall}, 32'd0);
      check("timeout_rdata_hold", cpu_rdata, 32'h0000_8001);
      @(posedge clk); #1;

      // Reset while waiting: everything returns to reset values, no response.
      @(negedge clk);
      cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_size = 2'b00; cpu_addr = 32'h0000_0200;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_en", {31'd0, mem_enable}, 32'd1);
      rst = 1'b0;
      #1;
      check_reset_vals("rst_wait");
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_done", {31'd0, cpu_done}, 32'd0);
      do_access("post_rst_ld", 1'b1, 2'b00, 1'b0, 32'h0000_0044, 32'd0, 32'h5A5A_1234, 1,
                32'h5A5A_1234, 32'h0000_0044);

      // Back-to-back with ready held high: one access every four cycles.
      @(negedge clk);
      d0 = done_cnt;
      cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_size = 2'b00; cpu_signed = 1'b0;
      cpu_addr = 32'h0000_0300;
      mem_rdata = 32'h0BAD_F00D; mem_data_ready = 1'b1;
      for (int i = 0; i < 3; i++) sb_q.push_back('{1'b0, 32'h0BAD_F00D});
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         check("b2b_gap", {31'd0, mem_enable & cpu_done}, 32'd0);
      end
      cpu_req = 1'b0; mem_data_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("b2b_done_count", done_cnt - d0, 32'd3);
      check("sb_empty", sb_q.size(), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
      $finish;
   end

endmodule
